// File: rtl/nanov_periph_hub_if.sv
// CPU-side bus of the nanoV peripheral hub: address/data strobes and data words.
interface nanov_periph_hub_if;
    logic        is_addr;
    logic        is_data;
    logic        is_data_in;
    logic [31:0] data_out;
    logic [31:0] data_in;

    modport master (
        output is_addr,
        output is_data,
        output is_data_in,
        output data_out,
        input  data_in
    );

    modport slave (
        input  is_addr,
        input  is_data,
        input  is_data_in,
        input  data_out,
        output data_in
    );
endinterface

// File: rtl/nanov_periph_hub.sv
// Memory-mapped peripheral hub for the nanoV bus: GPIO out/in with edge capture
// and interrupt, UART RX passthrough and a TX FIFO draining into uart_tx.
module nanov_periph_hub #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned GPIO_OUT_W = 32,
    parameter int unsigned GPIO_IN_W  = 8,
    parameter int unsigned TX_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    nanov_periph_hub_if.slave     bus,
    output logic [GPIO_OUT_W-1:0] gpio_out,
    input  logic [GPIO_IN_W-1:0]  gpio_in,
    output logic                  irq,
    output logic                  uart_tx_en,
    output logic [7:0]            uart_tx_data,
    input  logic                  uart_tx_busy,
    input  logic                  uart_rx_valid,
    input  logic [7:0]            uart_rx_data,
    output logic                  uart_rx_read
);
    localparam int unsigned PTR_W  = $clog2(TX_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned N_REGS = 6;
    localparam int unsigned R_GOUT = 0;
    localparam int unsigned R_GIN  = 1;
    localparam int unsigned R_EDGE = 2;
    localparam int unsigned R_IREN = 3;
    localparam int unsigned R_DATA = 4;
    localparam int unsigned R_STAT = 5;

    logic [N_REGS-1:0]    sel, sel_d;
    logic [31:0]          wdata;
    logic                 wr;
    logic [GPIO_IN_W-1:0] sync1, sync2, prev, rise, edge_r, irq_en, edge_clr;
    logic [7:0]           mem [TX_DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]     count;
    logic                 full, empty, push, pop, accept, tx_ovf, tx_idle;

    // Write data arrives bit-reversed; address decode compares each register slot exactly.
    always_comb begin
        wdata = '0;
        sel_d = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            wdata[i] = bus.data_out[31-i];
        end
        for (int unsigned i = 0; i < N_REGS; i++) begin
            sel_d[i] = (bus.data_out == BASE_ADDR + 32'(i * 4));
        end
    end

    // is_addr takes priority, so a simultaneous is_data never writes.
    assign wr       = bus.is_data & ~bus.is_addr;
    assign rise     = sync2 & ~prev;
    assign edge_clr = (wr && sel[R_EDGE]) ? wdata[GPIO_IN_W-1:0] : '0;

    assign full    = (count == CNT_W'(TX_DEPTH));
    assign empty   = (count == '0);
    assign push    = wr & sel[R_DATA];
    // Skipping the cycle after a pulse hides the delay before uart_tx raises busy.
    assign pop     = ~empty & ~uart_tx_busy & ~uart_tx_en;
    assign accept  = push & (~full | pop);
    assign tx_idle = empty & ~uart_tx_busy & ~uart_tx_en;

    assign uart_rx_read = sel[R_DATA] & bus.is_data_in;

    // Register select, loaded on each address phase and held until the next.
    always_ff @(posedge clk) begin
        if (!rstn) sel <= '0;
        else if (bus.is_addr) sel <= sel_d;
    end

    // GPIO output, IRQ enable, input synchroniser, edge capture and interrupt.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            gpio_out <= '0;
            irq_en   <= '0;
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            edge_r   <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && sel[R_GOUT]) gpio_out <= wdata[GPIO_OUT_W-1:0];
            if (wr && sel[R_IREN]) irq_en <= wdata[GPIO_IN_W-1:0];
            sync1  <= gpio_in;
            sync2  <= sync1;
            prev   <= sync2;
            edge_r <= (edge_r & ~edge_clr) | rise;
            irq    <= |(edge_r & irq_en);
        end
    end

    // FIFO storage; validity is tracked by pointers and count, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= wdata[7:0];
    end

    // FIFO pointers, occupancy, sticky overflow and the transmit start pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            tx_ovf       <= 1'b0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                uart_tx_data <= mem[rd_ptr];
            end
            uart_tx_en <= pop;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) tx_ovf <= 1'b1;
            else if (sel[R_STAT] && bus.is_data_in) tx_ovf <= 1'b0;
        end
    end

    // Read mux driven from the registered select; unselected reads return 0.
    always_comb begin
        bus.data_in = '0;
        if (sel[R_GOUT]) bus.data_in = 32'(gpio_out);
        if (sel[R_GIN])  bus.data_in = 32'(sync2);
        if (sel[R_EDGE]) bus.data_in = 32'(edge_r);
        if (sel[R_IREN]) bus.data_in = 32'(irq_en);
        if (sel[R_DATA]) bus.data_in = 32'(uart_rx_data);
        if (sel[R_STAT]) bus.data_in = 32'({count, tx_ovf, tx_idle, uart_rx_valid, full});
    end
endmodule

// File: tb/tb_nanov_periph_hub.sv
// Self-checking bench for nanov_periph_hub: register table, edge/irq, TX FIFO
// drain against a simple uart_tx model, RX passthrough and randomized register traffic.
module tb_nanov_periph_hub;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] gpio_out;
    logic [7:0]  gpio_in;
    logic        irq, uart_tx_en, uart_rx_valid, uart_rx_read, hold_busy;
    logic [7:0]  uart_tx_data, uart_rx_data;
    logic        uart_tx_busy;
    int unsigned tx_cnt;
    int unsigned total = 0, bad = 0;
    logic [7:0]  got[$];
    logic [7:0]  expq[$];

    nanov_periph_hub_if bus_if ();

    nanov_periph_hub #(.BASE_ADDR(BASE), .GPIO_OUT_W(32), .GPIO_IN_W(8), .TX_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .bus(bus_if), .gpio_out(gpio_out), .gpio_in(gpio_in),
        .irq(irq), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy), .uart_rx_valid(uart_rx_valid),
        .uart_rx_data(uart_rx_data), .uart_rx_read(uart_rx_read)
    );

    always #5 clk = ~clk;

    assign uart_tx_busy = hold_busy || (tx_cnt != 0);

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] exp_din;
        logic [31:0] exp_gpio;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rev(input logic [31:0] d);
        return {<<{d}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_addr(input logic [31:0] a);
        bus_if.is_addr  = 1'b1;
        bus_if.data_out = a;
        tick();
        bus_if.is_addr  = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] d);
        bus_if.is_data  = 1'b1;
        bus_if.data_out = rev(d);
        tick();
        bus_if.is_data  = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned n);
        for (int i = 0; i < 300 && got.size() < n; i++) tick();
        repeat (15) tick();
        chk("drain count", got.size(), n);
        while (got.size() > 0 && expq.size() > 0)
            chk("drain order", got.pop_front(), expq.pop_front());
        got.delete();
        expq.delete();
    endtask

    // Behavioural uart_tx: records each started byte and stays busy for 10 cycles.
    initial begin
        logic prev_en;
        tx_cnt  = 0;
        prev_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (uart_tx_en) begin
                chk("tx_en gap", 32'(prev_en), 0);
                got.push_back(uart_tx_data);
                tx_cnt = 10;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
            end
            prev_en = uart_tx_en;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[9];
        logic [31:0] mgpio;
        logic [7:0]  men, medge, mpin, p;
        int unsigned offs[10] = '{'h0, 'h4, 'h8, 'hC, 'h10, 'h14, 'h18, 'h40, 'h2, 'hE};
        int unsigned off, cur, k;
        logic [31:0] d, er;

        vecs[0] = '{BASE,        1'b1, 32'h1,         32'h1,         32'h1};
        vecs[1] = '{BASE + 'h40, 1'b1, 32'hFF,        32'h0,         32'h1};
        vecs[2] = '{BASE + 'h2,  1'b1, 32'h55,        32'h0,         32'h1};
        vecs[3] = '{BASE + 'hC,  1'b1, 32'h4,         32'h4,         32'h1};
        vecs[4] = '{BASE,        1'b1, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
        vecs[5] = '{BASE + 'h4,  1'b1, 32'h12,        32'h0,         32'hA5A5_0F0F};
        vecs[6] = '{BASE + 'h14, 1'b0, 32'h0,         32'h4,         32'hA5A5_0F0F};
        vecs[7] = '{BASE + 'hC,  1'b0, 32'h0,         32'h4,         32'hA5A5_0F0F};
        vecs[8] = '{BASE,        1'b1, 32'h1,         32'h1,         32'h1};

        rstn = 1'b0;
        bus_if.is_addr = 1'b0; bus_if.is_data = 1'b0; bus_if.is_data_in = 1'b0;
        bus_if.data_out = '0;
        gpio_in = '0; uart_rx_valid = 1'b0; uart_rx_data = '0; hold_busy = 1'b0;
        repeat (3) tick();
        chk("rst gpio_out", gpio_out, 0);
        chk("rst irq", 32'(irq), 0);
        chk("rst tx_en", 32'(uart_tx_en), 0);
        chk("rst tx_data", 32'(uart_tx_data), 0);
        chk("rst data_in", bus_if.data_in, 0);
        chk("rst rx_read", 32'(uart_rx_read), 0);
        rstn = 1'b1;
        do_addr(BASE + 'h14);
        chk("idle stat", bus_if.data_in, 32'h4);

        foreach (vecs[i]) begin
            do_addr(vecs[i].addr);
            if (vecs[i].wr) do_write(vecs[i].wdata);
            chk($sformatf("vec%0d data_in", i), bus_if.data_in, vecs[i].exp_din);
            chk($sformatf("vec%0d gpio_out", i), gpio_out, vecs[i].exp_gpio);
        end

        bus_if.is_addr = 1'b1; bus_if.is_data = 1'b1; bus_if.data_out = BASE;
        tick();
        bus_if.is_addr = 1'b0; bus_if.is_data = 1'b0;
        chk("addr+data no write", gpio_out, 32'h1);

        // Edge capture and irq timing, IRQ_EN = 4 from the table.
        do_addr(BASE + 'h8);
        gpio_in = 8'h04;
        tick(); tick();
        chk("edge early", bus_if.data_in, 0);
        tick();
        chk("edge set", bus_if.data_in, 32'h4);
        chk("irq early", 32'(irq), 0);
        tick();
        chk("irq rise", 32'(irq), 1);
        gpio_in = 8'h00;
        do_write(32'h4);
        chk("edge clear", bus_if.data_in, 0);
        tick();
        chk("irq fall", 32'(irq), 0);
        repeat (2) tick();
        gpio_in = 8'h04;
        tick(); tick();
        bus_if.is_data = 1'b1; bus_if.data_out = rev(32'h4);
        tick();
        bus_if.is_data = 1'b0;
        chk("edge set wins", bus_if.data_in, 32'h4);
        tick();
        chk("irq after collision", 32'(irq), 1);
        gpio_in = 8'h00;
        repeat (3) tick();
        do_write(32'h4);
        tick();

        // Overflow with busy held, then drain in order.
        hold_busy = 1'b1;
        do_addr(BASE + 'h10);
        for (int i = 0; i <= DEPTH; i++) begin
            do_write(32'(8'h11 * (i + 1)));
            if (i < DEPTH) expq.push_back(8'(8'h11 * (i + 1)));
        end
        do_addr(BASE + 'h14);
        chk("stat full ovf", bus_if.data_in, 32'h49);
        bus_if.is_data_in = 1'b1;
        tick();
        bus_if.is_data_in = 1'b0;
        chk("stat ovf cleared", bus_if.data_in, 32'h41);
        hold_busy = 1'b0;
        wait_drain(DEPTH);
        chk("stat idle", bus_if.data_in, 32'h4);

        // Push into a full FIFO on the same edge as a drain pop.
        hold_busy = 1'b1;
        do_addr(BASE + 'h10);
        for (int i = 0; i < DEPTH; i++) begin
            do_write(32'(8'hA1 + i));
            expq.push_back(8'(8'hA1 + i));
        end
        hold_busy = 1'b0;
        bus_if.is_data = 1'b1; bus_if.data_out = rev(32'hB5);
        expq.push_back(8'hB5);
        tick();
        bus_if.is_data = 1'b0;
        chk("pop with push", 32'(uart_tx_en), 1);
        do_addr(BASE + 'h14);
        chk("full push accepted", bus_if.data_in, 32'h41);
        wait_drain(DEPTH + 1);
        chk("stat idle 2", bus_if.data_in, 32'h4);

        // Receive path.
        uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
        #1;
        chk("stat rx_valid", bus_if.data_in, 32'h6);
        do_addr(BASE + 'h10);
        chk("rx data", bus_if.data_in, 32'h5A);
        chk("rx_read idle", 32'(uart_rx_read), 0);
        bus_if.is_data_in = 1'b1;
        #1;
        chk("rx_read pulse", 32'(uart_rx_read), 1);
        tick();
        bus_if.is_data_in = 1'b0;
        #1;
        chk("rx_read drop", 32'(uart_rx_read), 0);
        uart_rx_valid = 1'b0;

        // Reset while bytes are queued discards them.
        hold_busy = 1'b1;
        do_addr(BASE + 'h10);
        do_write(32'h77);
        do_write(32'h88);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        hold_busy = 1'b0;
        repeat (30) tick();
        chk("reset flush", got.size(), 0);
        chk("reset gpio_out", gpio_out, 0);
        do_addr(BASE + 'h14);
        chk("reset stat", bus_if.data_in, 32'h4);
        got.delete();

        // Random register traffic against an abstract register-map model.
        mgpio = '0; men = '0; medge = '0; mpin = '0; cur = 'h40;
        for (int n = 0; n < 80; n++) begin
            k   = $urandom_range(0, 2);
            off = offs[$urandom_range(0, 9)];
            uart_rx_valid = 1'($urandom_range(0, 1));
            uart_rx_data  = 8'($urandom);
            if (k == 0) begin
                p = 8'($urandom);
                gpio_in = p;
                medge = medge | (p & ~mpin);
                mpin  = p;
                repeat (4) tick();
            end else if (k == 1 && off != 'h10) begin
                do_addr(BASE + off);
                cur = off;
                d = $urandom;
                do_write(d);
                if (off == 'h0) mgpio = d;
                if (off == 'h8) medge = medge & ~d[7:0];
                if (off == 'hC) men = d[7:0];
                tick();
            end else begin
                do_addr(BASE + off);
                cur = off;
            end
            case (cur)
                'h0:     er = mgpio;
                'h4:     er = 32'(mpin);
                'h8:     er = 32'(medge);
                'hC:     er = 32'(men);
                'h10:    er = 32'(uart_rx_data);
                'h14:    er = 32'h4 | (32'(uart_rx_valid) << 1);
                default: er = '0;
            endcase
            chk("rnd gpio_out", gpio_out, mgpio);
            chk("rnd irq", 32'(irq), 32'(|(medge & men)));
            chk("rnd data_in", bus_if.data_in, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nanov_periph_hub.md
# nanov_periph_hub

Parametrised memory-mapped peripheral hub for the nanoV bit-serial CPU bus. It replaces the fixed GPIO/UART address decode in the board top level. It adds a configurable base address, GPIO widths, synchronised inputs with rising-edge capture and an interrupt line, and a TX FIFO in front of the external `uart_tx`. It sits between the CPU's `is_addr`/`is_data`/`is_data_in`/`data_out`/`data_in` signals and the board pins and UART cores.

## Interface
- `BASE_ADDR`, 32'h10000000: base of the 6-word register window.
- `GPIO_OUT_W`, 32: GPIO output width, 1..32.
- `GPIO_IN_W`, 8: GPIO input width, 1..32.
- `TX_DEPTH`, 4: TX FIFO depth, a power of two in 2..16.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `is_addr` in 1: `data_out` carries the bus address this cycle.
- `is_data` in 1: `data_out` carries write data this cycle.
- `is_data_in` in 1: the CPU consumes `data_in` this cycle.
- `data_out` in 32: bus word. The address is used as-is; write data arrives bit-reversed and is reversed internally.
- `data_in` out 32: read data, combinational from the registered select.
- `gpio_out` out GPIO_OUT_W: GPIO output register.
- `gpio_in` in GPIO_IN_W: asynchronous GPIO inputs.
- `irq` out 1: registered interrupt, equal to OR of (EDGE & IRQ_EN).
- `uart_tx_en` out 1: one-cycle start pulse to `uart_tx`.
- `uart_tx_data` out 8: byte presented with `uart_tx_en`.
- `uart_tx_busy` in 1: the transmitter is busy.
- `uart_rx_valid` in 1, `uart_rx_data` in 8: receiver status and byte.
- `uart_rx_read` out 1: receive byte consumed.

## Operation
Register map, offsets from BASE_ADDR. In the list below, "wdata" means the write data after bit-reversal.
- 0x00 GPIO_OUT, RW: `gpio_out` = wdata[GPIO_OUT_W-1:0].
- 0x04 GPIO_IN, RO: value of the 2-flop synchronised inputs.
- 0x08 EDGE, RW1C: a bit sets on each synchronised rising edge. Writing 1 clears the bit. If a set and a clear hit the same bit in the same cycle, the set wins.
- 0x0C IRQ_EN, RW, width GPIO_IN_W.
- 0x10 UART_DATA:
  - Write pushes wdata[7:0] into the TX FIFO.
  - Read returns `uart_rx_data`.
  - `uart_rx_read` = sel_data & `is_data_in`.
- 0x14 UART_STAT, RO:
  - bit0 tx_full.
  - bit1 `uart_rx_valid`.
  - bit2 tx_idle: FIFO empty, `uart_tx_busy` low and `uart_tx_en` low.
  - bit3 tx_overflow, a sticky bit.
  - bits[8:4] tx_count.
  - `is_data_in` while UART_STAT is selected clears tx_overflow. If an overflow occurs in that same cycle, set wins.

Address decode:
- On `is_addr`, a registered one-hot select is loaded from an exact compare of `data_out` against BASE+offset.
- Any other address, including a misaligned one, selects nothing. Writes to a non-selected address are ignored. `data_in` reads 0.
- The select holds until the next `is_addr`.
- Unused high bits of `data_in` read 0.

TX FIFO:
- Circular buffer with read pointer, write pointer and a count of width clog2(TX_DEPTH)+1.
- A push while count==TX_DEPTH is dropped and sets tx_overflow, unless a pop occurs in the same cycle; in that case the push is accepted.
- Pointers wrap modulo TX_DEPTH.

Drain logic:
- Condition: count>0, `uart_tx_busy`=0, and `uart_tx_en` was not asserted in the previous cycle. The one-cycle guard covers the latency of `busy` rising in `uart_tx`.
- When the condition holds, `uart_tx_en` is asserted for exactly one cycle with `uart_tx_data` = head byte, and the FIFO pops in the same cycle.

## Timing
Reset values, applied when `rstn`=0 on a clock edge:
- select: none.
- `gpio_out`: 0.
- EDGE, IRQ_EN, sync flops and previous-sample register: 0.
- FIFO empty, pointers 0, tx_overflow 0.
- `uart_tx_en`: 0. `uart_tx_data`: 0.
- `irq`: 0.
- Reset mid-transfer discards FIFO contents. A byte already handed to `uart_tx` is not affected.

Latencies:
- Select is valid one cycle after `is_addr`. `data_in` is valid from that cycle onward.
- A write takes effect on the edge ending the `is_data` cycle: `gpio_out` and registers are updated the next cycle.
- `is_data` and `is_addr` in the same cycle: `is_addr` wins, and no write occurs.
- A `gpio_in` change reaches GPIO_IN 2 cycles later. The EDGE bit sets 3 cycles after the pin change, and `irq` rises 1 cycle after that.
- Push to empty FIFO with `uart_tx_busy`=0: `uart_tx_en` pulses the cycle after the push.
- Back-to-back pulses are separated by at least one cycle and by `uart_tx_busy` falling.
- `uart_rx_read` is combinational, asserted in the same cycle as `is_data_in`.

## Test plan
- Reset, then check idle state: all outputs are 0, and reading 0x14 gives bit2=1, count=0.
- Address BASE, then write data_out=32'h80000000 (bit-reversed 1) -> `gpio_out`=1 one cycle after `is_data`. Address BASE+0x40 and write -> `gpio_out` unchanged, and a read returns 0.
- Pulse `gpio_in[2]` high with IRQ_EN=4 -> EDGE=4 after 3 cycles and `irq`=1 one cycle later. Write 4 to EDGE -> `irq` falls. Apply an edge in the same cycle as the clear -> the bit stays set.
- With `uart_tx_busy` held high, push TX_DEPTH+1 bytes -> count=TX_DEPTH, tx_full=1 and tx_overflow=1. Reading STAT clears overflow.
- Release busy and model a `uart_tx` that is busy for 10 cycles -> bytes leave in FIFO order, one `uart_tx_en` per byte, and tx_idle=1 at the end.
- With the FIFO full, push in the same cycle as a drain pop -> the push is accepted, count unchanged, overflow stays 0. With `uart_rx_valid`=1, a read of 0x10 asserts `uart_rx_read` for exactly the `is_data_in` cycle.
